player_motion_ctrl: RTL

- Next-generation player controller for the 640x480 VGA game.
- Adds four-direction movement with per-axis velocity, acceleration, friction and speed saturation.
- Adds a lives counter, a timed invincibility (shield) state with sprite blinking, and a game-over state.
- Sits between the keypad/collision logic and the player sprite drawer. All motion updates occur on the startOfFrame pulse.

---
 rtl/player_motion_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/player_motion_ctrl.sv
// Player controller: fixed-point motion, lives, shield and game over.
// Frame-rate state updates on startOfFrame; outputs come from registers.
module player_motion_ctrl #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int INITIAL_X     = 303,
  parameter int INITIAL_Y     = 447,
  parameter int IMAGE_WIDTH   = 32,
  parameter int IMAGE_HEIGHT  = 32,
  parameter int FRAC_BITS     = 6,
  parameter int ACCEL         = 32,
  parameter int FRICTION      = 16,
  parameter int MAX_SPEED     = 256,
  parameter int LIVES         = 3,
  parameter int SHIELD_FRAMES = 90,
  parameter int BLINK_FRAMES  = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  input  logic               collision,
  input  logic               invincibleReq,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               playerVisible,
  output logic               shieldActive,
  output logic [3:0]         livesLeft,
  output logic               gameOver
);

  localparam int W  = 11 + FRAC_BITS + 3;
  localparam int CW = $clog2(SHIELD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  typedef logic signed [W-1:0] fx_t;

  localparam int X0I   = INITIAL_X << FRAC_BITS;
  localparam int Y0I   = INITIAL_Y << FRAC_BITS;
  localparam int XMAXI = (SCREEN_WIDTH - IMAGE_WIDTH) << FRAC_BITS;
  localparam int YMAXI = (SCREEN_HEIGHT - IMAGE_HEIGHT) << FRAC_BITS;

  localparam fx_t X0   = fx_t'(X0I);
  localparam fx_t Y0   = fx_t'(Y0I);
  localparam fx_t XMAX = fx_t'(XMAXI);
  localparam fx_t YMAX = fx_t'(YMAXI);
  localparam fx_t ACC  = fx_t'(ACCEL);
  localparam fx_t FRI  = fx_t'(FRICTION);
  localparam fx_t VMAX = fx_t'(MAX_SPEED);
  localparam fx_t VMIN = fx_t'(-MAX_SPEED);
  localparam fx_t ZERO = '0;

  localparam logic [CW-1:0] SHF  = CW'(SHIELD_FRAMES);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [BW-1:0] BLST = BW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BONE = BW'(1);
  localparam logic [3:0]    LV   = 4'(LIVES);
  localparam logic [3:0]    LONE = 4'd1;

  typedef enum logic [1:0] {
    NORMAL,
    SHIELD,
    DEAD
  } state_t;

  state_t        state_q, state_n;
  fx_t           px_q, px_n, py_q, py_n;
  fx_t           vx_q, vx_n, vy_q, vy_n;
  fx_t           vxs, vys, pxs, pys;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [BW-1:0] blk_q, blk_n;
  logic          vis_q, vis_n;
  logic [3:0]    lives_q, lives_n;
  logic          col_q, col_n;
  logic          inv_q, inv_n;
  logic          colEv, invEv;

  function automatic fx_t vel_step(
    input fx_t  v,
    input logic pos,
    input logic neg
  );
    fx_t t;
    t = v;
    unique case (1'b1)
      (pos && !neg): begin
        t = v + ACC;
        if (t > VMAX) t = VMAX;
      end
      (neg && !pos): begin
        t = v - ACC;
        if (t < VMIN) t = VMIN;
      end
      default: begin
        if (v > FRI)       t = v - FRI;
        else if (v < -FRI) t = v + FRI;
        else               t = ZERO;
      end
    endcase
    return t;
  endfunction

  function automatic logic out_of(
    input fx_t p,
    input fx_t pmax
  );
    return (p < ZERO) || (p > pmax);
  endfunction

  function automatic fx_t clampf(
    input fx_t p,
    input fx_t pmax
  );
    fx_t t;
    t = p;
    if (p < ZERO)      t = ZERO;
    else if (p > pmax) t = pmax;
    return t;
  endfunction

  assign colEv = col_q | collision;
  assign invEv = inv_q | invincibleReq;

  // Next-state: event latches, per-frame motion and life/shield FSM
  always_comb begin
    state_n = state_q;
    px_n    = px_q;
    py_n    = py_q;
    vx_n    = vx_q;
    vy_n    = vy_q;
    cnt_n   = cnt_q;
    blk_n   = blk_q;
    vis_n   = vis_q;
    lives_n = lives_q;
    col_n   = colEv;
    inv_n   = invEv;
    vxs     = vel_step(vx_q, right, left);
    vys     = vel_step(vy_q, down, up);
    pxs     = px_q + vxs;
    pys     = py_q + vys;
    if (startOfFrame) begin
      col_n = 1'b0;
      inv_n = 1'b0;
      if (state_q != DEAD) begin
        px_n = clampf(pxs, XMAX);
        py_n = clampf(pys, YMAX);
        vx_n = out_of(pxs, XMAX) ? ZERO : vxs;
        vy_n = out_of(pys, YMAX) ? ZERO : vys;
      end
      unique case (state_q)
        NORMAL: begin
          if (invEv) begin
            state_n = SHIELD;
            cnt_n   = SHF;
            blk_n   = '0;
            vis_n   = 1'b0;
          end else if (colEv) begin
            lives_n = lives_q - LONE;
            vx_n    = ZERO;
            vy_n    = ZERO;
            vis_n   = 1'b0;
            if (lives_q == LONE) begin
              state_n = DEAD;
            end else begin
              state_n = SHIELD;
              cnt_n   = SHF;
              blk_n   = '0;
            end
          end
        end
        SHIELD: begin
          if (blk_q == BLST) begin
            blk_n = '0;
            vis_n = ~vis_q;
          end else begin
            blk_n = blk_q + BONE;
          end
          if (invEv) begin
            cnt_n = SHF;
          end else if (cnt_q == CONE) begin
            cnt_n   = '0;
            blk_n   = '0;
            vis_n   = 1'b1;
            state_n = NORMAL;
          end else begin
            cnt_n = cnt_q - CONE;
          end
        end
        DEAD: begin
          vx_n  = ZERO;
          vy_n  = ZERO;
          vis_n = 1'b0;
        end
        default: state_n = NORMAL;
      endcase
    end
  end

  // State register with asynchronous restore to power-on values
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= NORMAL;
      px_q    <= X0;
      py_q    <= Y0;
      vx_q    <= ZERO;
      vy_q    <= ZERO;
      cnt_q   <= '0;
      blk_q   <= '0;
      vis_q   <= 1'b1;
      lives_q <= LV;
      col_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      px_q    <= px_n;
      py_q    <= py_n;
      vx_q    <= vx_n;
      vy_q    <= vy_n;
      cnt_q   <= cnt_n;
      blk_q   <= blk_n;
      vis_q   <= vis_n;
      lives_q <= lives_n;
      col_q   <= col_n;
      inv_q   <= inv_n;
    end
  end

  assign topLeftX      = px_q[FRAC_BITS+10:FRAC_BITS];
  assign topLeftY      = py_q[FRAC_BITS+10:FRAC_BITS];
  assign playerVisible = vis_q;
  assign shieldActive  = (state_q == SHIELD);
  assign gameOver      = (state_q == DEAD);
  assign livesLeft     = lives_q;

endmodule
